// File: rtl/ps2_keycode_rx_pkg.sv
// Shared keycodes, receive-FSM state encoding and a parity helper
// for the PS/2 keycode receiver.
package ps2_keycode_rx_pkg;

    localparam logic [7:0] KP_INVALID      = 8'h00;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
    localparam logic [7:0] KP_EXTENDED     = 8'hE0;

    localparam logic [7:0] KP_0     = 8'h70;
    localparam logic [7:0] KP_1     = 8'h69;
    localparam logic [7:0] KP_2     = 8'h72;
    localparam logic [7:0] KP_3     = 8'h7A;
    localparam logic [7:0] KP_4     = 8'h6B;
    localparam logic [7:0] KP_5     = 8'h73;
    localparam logic [7:0] KP_6     = 8'h74;
    localparam logic [7:0] KP_7     = 8'h6C;
    localparam logic [7:0] KP_8     = 8'h75;
    localparam logic [7:0] KP_9     = 8'h7D;
    localparam logic [7:0] KP_STAR  = 8'h7C;
    localparam logic [7:0] KP_MINUS = 8'h7B;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DATA   = 4'd1,
        ST_PARITY = 4'd2,
        ST_STOP   = 4'd3
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keycode output bundle of the PS/2 receiver.
// key: presented code; key_strobe: update pulse; frame_err: discard pulse.
interface ps2_keycode_rx_if;
    logic [7:0] key;
    logic       key_strobe;
    logic       frame_err;

    modport master (output key, output key_strobe, output frame_err);
    modport slave  (input  key, input  key_strobe, input  frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser + glitch filter for a raw PS/2 line; emits a one-clock
// pulse on each filtered falling edge. Ports: clk, reset (async low), raw, fall.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   level;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // The level flips only after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserialises frames, drops E0, presents key codes.
// Ports: clk, reset (async low), ps2_clk, ps2_data, kp (key/key_strobe/frame_err),
// debug_state_out. Optional PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_keycode_rx
    import ps2_keycode_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    ps2_keycode_rx_if.master       kp,
    output logic [3:0]             debug_state_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    rx_state_t state, state_n;

    logic                   fall;
    logic [SYNC_STAGES-1:0] dsync;
    logic                   d;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [TW-1:0]          to_cnt;
    logic                   par_bad;
    logic                   byte_vld;

    logic shift_en;
    logic par_chk;
    logic par_fail;
    logic stop_ok;
    logic stop_bad;
    logic to_err;
    logic err_ev;
    logic acc_ev;

    logic [7:0] key;
    logic       key_strobe;
    logic       frame_err;
    logic       strobe_n;
    logic       rel_pend;
    logic       brk_hold;
    logic       err_pend;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsync <= '1;
        end else begin
            dsync <= {dsync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign d = dsync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
    assign par_fail = !odd_ok(shreg, d);
`else
    assign par_fail = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_chk  = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        to_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fall && !d) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_chk = 1'b1;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_n  = ST_IDLE;
                    stop_ok  = d;
                    stop_bad = !d;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (state != ST_IDLE && !fall && to_cnt == TO_MAX) begin
            to_err  = 1'b1;
            state_n = ST_IDLE;
        end
    end

    // A parity failure is reported at PARITY; the later stop check
    // then only decides nothing further for this frame.
    assign err_ev = to_err
                  | (par_chk & par_fail)
                  | (stop_bad & !par_bad);
    assign acc_ev = stop_ok & !par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            to_cnt   <= '0;
            par_bad  <= 1'b0;
            byte_vld <= 1'b0;
        end else begin
            state    <= state_n;
            byte_vld <= acc_ev;
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
                par_bad <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) shreg <= {d, shreg[7:1]};
            if (par_chk) par_bad <= par_fail;
            if (state == ST_IDLE || fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // shreg is stable while byte_vld is high: the FSM is back in IDLE.
    assign strobe_n = byte_vld && (shreg != KP_EXTENDED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key        <= KP_INVALID;
            key_strobe <= 1'b0;
            rel_pend   <= 1'b0;
            brk_hold   <= 1'b0;
        end else begin
            key_strobe <= strobe_n;
            brk_hold   <= 1'b0;
            if (byte_vld) begin
                if (shreg == KP_EXTENDED) begin
                    key <= key;
                end else if (shreg == KP_KEY_RELEASED) begin
                    key      <= KP_KEY_RELEASED;
                    rel_pend <= 1'b1;
                end else begin
                    key <= shreg;
                    if (rel_pend) begin
                        brk_hold <= 1'b1;
                        rel_pend <= 1'b0;
                    end
                end
            end else if (brk_hold) begin
                key <= KP_INVALID;
            end
        end
    end

    // An error that would land on a strobe clock waits one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            err_pend  <= 1'b0;
        end else begin
            frame_err <= (err_ev | err_pend) & !strobe_n;
            err_pend  <= (err_ev | err_pend) & strobe_n;
        end
    end

    assign kp.key          = key;
    assign kp.key_strobe   = key_strobe;
    assign kp.frame_err    = frame_err;
    assign debug_state_out = state;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed scenarios plus a
// randomized key stream checked against a byte-level presentation model.
module tb_ps2_keycode_rx;
    import ps2_keycode_rx_pkg::*;

    localparam int SYNC = 2;
    localparam int FLEN = 8;
    localparam int TOUT = 400;
    localparam int H    = 20;
    localparam int LAT  = SYNC + FLEN + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] dbg;

    ps2_keycode_rx_if kp ();

    ps2_keycode_rx #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .kp              (kp),
        .debug_state_out (dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fall_cyc = 0;

    logic [7:0] stb_q[$];
    int         chg_cyc[$];
    logic [7:0] chg_val[$];
    int         err_n = 0;
    int         overlap_n = 0;
    logic [7:0] prev_key = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (kp.key_strobe) stb_q.push_back(kp.key);
            if (kp.frame_err) err_n++;
            if (kp.key_strobe && kp.frame_err) overlap_n++;
            if (kp.key !== prev_key) begin
                chg_cyc.push_back(cyc);
                chg_val.push_back(kp.key);
            end
        end
        prev_key = kp.key;
    end

    task automatic clear_mon();
        stb_q.delete();
        chg_cyc.delete();
        chg_val.delete();
        err_n = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        clear_mon();
    endtask

    // Drives frame bits 0..nbits-1 (start, d0..d7, parity, stop).
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_bit, input int nbits,
                              input bit glitch);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (H / 2) @(posedge clk);
            #1 ps2_data = bits[i];
            if (glitch) begin
                @(posedge clk);
                #1 ps2_clk = 1'b0;
                @(posedge clk);
                #1 ps2_clk = 1'b1;
            end
            repeat (H / 2) @(posedge clk);
            #1 ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            ps2_data = 1'b1;
            repeat (3 * H) @(posedge clk);
        end
    endtask

    task automatic send_ok(input logic [7:0] b, input bit glitch);
        send_frame(b, 1'b0, 1'b1, 11, glitch);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (kp.key !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_key got %h exp 00", kp.key);
        end
        n_checks++;
        if (kp.key_strobe !== 1'b0 || kp.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b%b exp 00",
                     kp.key_strobe, kp.frame_err);
        end
        n_checks++;
        if (dbg !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d exp 0", dbg);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_ok(8'h69, 1'b0);
        n_checks++;
        if (stb_q.size() != 1 || kp.key !== 8'h69) begin
            n_fail++;
            $display("FAIL single_69 got key %h strobes %0d exp 69/1",
                     kp.key, stb_q.size());
        end
        n_checks++;
        if (chg_cyc.size() != 1 || chg_cyc[0] - last_fall_cyc != LAT) begin
            n_fail++;
            $display("FAIL single_latency got %0d exp %0d",
                     chg_cyc.size() ? chg_cyc[0] - last_fall_cyc : -1, LAT);
        end
        repeat (100) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (kp.key !== 8'h69 || stb_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_hold got %h exp 69", kp.key);
        end
    endtask

    task automatic test_release();
        logic [7:0] exp_v[4];
        exp_v = '{8'h69, 8'hF0, 8'h69, 8'h00};
        do_reset();
        send_ok(8'h69, 1'b0);
        send_ok(8'hF0, 1'b0);
        send_ok(8'h69, 1'b0);
        n_checks++;
        if (stb_q.size() != 3) begin
            n_fail++;
            $display("FAIL release_strobes got %0d exp 3", stb_q.size());
        end
        n_checks++;
        if (chg_val.size() != 4) begin
            n_fail++;
            $display("FAIL release_changes got %0d exp 4", chg_val.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (chg_val[i] !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL release_seq[%0d] got %h exp %h",
                             i, chg_val[i], exp_v[i]);
                end
            end
            n_checks++;
            if (chg_cyc[3] - chg_cyc[2] != 1) begin
                n_fail++;
                $display("FAIL release_hold got %0d clks exp 1",
                         chg_cyc[3] - chg_cyc[2]);
            end
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_ok(8'h69, 1'b0);
        clear_mon();
        send_frame(8'h7C, 1'b1, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        n_checks++;
        if (err_n != 1 || stb_q.size() != 0 || kp.key !== 8'h69) begin
            n_fail++;
            $display("FAIL parity_bad got err %0d stb %0d key %h exp 1/0/69",
                     err_n, stb_q.size(), kp.key);
        end
`else
        n_checks++;
        if (err_n != 0 || stb_q.size() != 1 || kp.key !== 8'h7C) begin
            n_fail++;
            $display("FAIL parity_ign got err %0d stb %0d key %h exp 0/1/7c",
                     err_n, stb_q.size(), kp.key);
        end
`endif
    endtask

    task automatic test_stop_err();
        do_reset();
        send_frame(8'h7B, 1'b0, 1'b0, 11, 1'b0);
        n_checks++;
        if (err_n != 1 || stb_q.size() != 0 || kp.key !== 8'h00) begin
            n_fail++;
            $display("FAIL stop_err got err %0d stb %0d key %h exp 1/0/00",
                     err_n, stb_q.size(), kp.key);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dbg !== 4'd1) begin
            n_fail++;
            $display("FAIL timeout_mid state got %0d exp 1", dbg);
        end
        repeat (TOUT + 50) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_n != 1 || dbg !== 4'd0 || stb_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout got err %0d state %0d exp 1/0",
                     err_n, dbg);
        end
        send_ok(8'h7B, 1'b0);
        n_checks++;
        if (kp.key !== 8'h7B || stb_q.size() != 1 || err_n != 1) begin
            n_fail++;
            $display("FAIL timeout_next got %h exp 7b", kp.key);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_ok(8'h69, 1'b0);
        clear_mon();
        send_frame(8'h70, 1'b0, 1'b1, 6, 1'b0);
        repeat (H / 2) @(posedge clk);
        #1 ps2_data = 1'b1;
        repeat (H / 2) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (kp.key !== 8'h00 || kp.key_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got %h exp 00", kp.key);
        end
        repeat (H) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        n_checks++;
        if (stb_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_stb got %0d exp 0", stb_q.size());
        end
        send_ok(8'h70, 1'b0);
        n_checks++;
        if (kp.key !== 8'h70 || stb_q.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_next got %h exp 70", kp.key);
        end
    endtask

    task automatic test_extended(input bit glitch);
        do_reset();
        send_ok(8'hE0, glitch);
        n_checks++;
        if (stb_q.size() != 0 || kp.key !== 8'h00) begin
            n_fail++;
            $display("FAIL ext_e0 g%0d got stb %0d key %h exp 0/00",
                     glitch, stb_q.size(), kp.key);
        end
        send_ok(8'h4A, glitch);
        n_checks++;
        if (stb_q.size() != 1 || kp.key !== 8'h4A || err_n != 0) begin
            n_fail++;
            $display("FAIL ext_4a g%0d got stb %0d key %h exp 1/4a",
                     glitch, stb_q.size(), kp.key);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[12];
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [7:0] exp_key;
        bit         rel;
        pool = '{KP_0, KP_1, KP_2, KP_3, KP_4, KP_5, KP_6, KP_7,
                 KP_8, KP_9, KP_STAR, KP_MINUS};
        do_reset();
        exp_key = 8'h00;
        rel = 0;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 5))
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: begin
                    b = 8'($urandom_range(1, 8'hDF));
                end
                default: b = pool[$urandom_range(0, 11)];
            endcase
            send_ok(b, $urandom_range(0, 1) == 1);
            if (b == 8'hE0) begin
            end else if (b == 8'hF0) begin
                exp_q.push_back(b);
                exp_key = 8'hF0;
                rel = 1;
            end else begin
                exp_q.push_back(b);
                exp_key = rel ? 8'h00 : b;
                rel = 0;
            end
        end
        n_checks++;
        if (stb_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count got %0d exp %0d",
                     stb_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (stb_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_strobe[%0d] got %h exp %h",
                             i, stb_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (kp.key !== exp_key || err_n != 0) begin
            n_fail++;
            $display("FAIL rand_key got %h err %0d exp %h/0",
                     kp.key, err_n, exp_key);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        test_reset();
        #1 rst_n = 1'b1;
        test_single();
        test_release();
        test_parity();
        test_stop_err();
        test_timeout();
        test_reset_mid();
        test_extended(1'b0);
        test_extended(1'b1);
        test_random();
        n_checks++;
        if (overlap_n != 0) begin
            n_fail++;
            $display("FAIL strobe_err_overlap got %0d exp 0", overlap_n);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
